// File: rtl/cp0_if.sv
// Bus between the control unit (master) and the coprocessor-0 responder (slave).
interface cp0_if;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic        eret_in;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata;
  logic [31:0] epc_out;
  logic        req;
  logic [31:0] exc_pc;

  modport master (
    output we, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, eret_in, hw_int,
    input  cp0_rdata, epc_out, req, exc_pc
  );

  modport slave (
    input  we, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, eret_in, hw_int,
    output cp0_rdata, epc_out, req, exc_pc
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 responder: SR/Cause/EPC/PRId/Count/Compare, interrupt and
// exception arbitration, eret return and a Count/Compare timer on IP[5].
module cp0_unit #(
  parameter logic [31:0] PRID         = 32'h4255_4141,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input logic  clk,
  input logic  reset,
  cp0_if.slave bus
);
  typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_e;

  state_e      state_q;
  logic [5:0]  im_q;
  logic        ie_q;
  logic        bd_q;
  logic [5:0]  ip_q;
  logic [5:0]  ip_d;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;
  logic [31:0] epc_d;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        tim_pend_q;
  logic        exl;
  logic        int_req;
  logic        exc_req;
  logic        req;
  logic        wr;
  logic [31:0] vpc_adj;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  always_comb begin
    ip_d    = {bus.hw_int[5] | tim_pend_q, bus.hw_int[4:0]};
    exl     = (state_q == HANDLER);
    int_req = (|(ip_d & im_q)) & ie_q & ~exl;
    exc_req = (bus.exc_code_in != 5'd0) & ~exl;
    req     = ~reset & (int_req | exc_req);
    wr      = bus.we & ~req;
    vpc_adj = bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
    epc_d   = {vpc_adj[31:2], 2'b00};
  end

  always_comb begin
    sr_word    = {16'b0, im_q, 8'b0, exl, ie_q};
    cause_word = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b00};
    unique case (bus.cp0_addr)
      5'd9:    bus.cp0_rdata = count_q;
      5'd11:   bus.cp0_rdata = compare_q;
      5'd12:   bus.cp0_rdata = sr_word;
      5'd13:   bus.cp0_rdata = cause_word;
      5'd14:   bus.cp0_rdata = epc_q;
      5'd15:   bus.cp0_rdata = PRID;
      default: bus.cp0_rdata = '0;
    endcase
  end

  assign bus.epc_out = (bus.we && bus.cp0_addr == 5'd14) ? {bus.cp0_wdata[31:2], 2'b00} : epc_q;
  assign bus.req     = req;
  assign bus.exc_pc  = HANDLER_ADDR;

  // Later assignments override earlier ones: a taken request beats eret and
  // the mtc0 (which is squashed anyway); Compare writes beat the timer match.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      im_q       <= '0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      count_q    <= '0;
      compare_q  <= '1;
      tim_pend_q <= 1'b0;
    end else begin
      ip_q    <= ip_d;
      count_q <= count_q + 32'd1;
      if (count_q == compare_q) tim_pend_q <= 1'b1;
      if (wr) begin
        unique case (bus.cp0_addr)
          5'd9:  count_q <= bus.cp0_wdata;
          5'd11: begin
            compare_q  <= bus.cp0_wdata;
            tim_pend_q <= 1'b0;
          end
          5'd12: begin
            im_q    <= bus.cp0_wdata[15:10];
            ie_q    <= bus.cp0_wdata[0];
            state_q <= bus.cp0_wdata[1] ? HANDLER : RUN;
          end
          5'd14: epc_q <= {bus.cp0_wdata[31:2], 2'b00};
          default: ;
        endcase
      end
      if (req) begin
        state_q    <= HANDLER;
        bd_q       <= bus.bd_in;
        exc_code_q <= int_req ? 5'd0 : bus.exc_code_in;
        epc_q      <= epc_d;
      end else if (bus.eret_in && state_q == HANDLER) begin
        state_q <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: word-level register model checked every cycle
// plus literal expectations for the documented scenarios.
module tb_cp0_unit;
  logic clk;
  logic reset;
  cp0_if bus();

  cp0_unit #(.PRID(32'h4255_4141), .HANDLER_ADDR(32'h0000_4180)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  bit live  = 0;

  // register model, whole 32-bit words
  logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
  logic        m_pend;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] m_ipn();
    return {bus.hw_int[5] | m_pend, bus.hw_int[4:0]};
  endfunction

  function automatic logic m_int();
    return (|(m_ipn() & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return !reset && (m_int() || (bus.exc_code_in != 5'd0 && !m_sr[1]));
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h4255_4141;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_next_sr();
    logic [31:0] s;
    s = m_sr;
    if (m_req()) return s | 32'h2;
    if (bus.we && bus.cp0_addr == 5'd12) s = bus.cp0_wdata & 32'h0000_FC03;
    if (bus.eret_in && m_sr[1]) s = s & ~32'h2;
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_sr <= 32'h0; m_cause <= 32'h0; m_epc <= 32'h0;
      m_count <= 32'h0; m_compare <= 32'hFFFF_FFFF; m_pend <= 1'b0;
    end else begin
      m_sr <= m_next_sr();
      if (m_req()) begin
        m_cause <= {bus.bd_in, 15'b0, m_ipn(), 3'b0, (m_int() ? 5'd0 : bus.exc_code_in), 2'b0};
        m_epc   <= (bus.bd_in ? bus.vpc - 32'd4 : bus.vpc) & ~32'h3;
      end else begin
        m_cause <= {m_cause[31:16], m_ipn(), m_cause[9:0]};
        if (bus.we && bus.cp0_addr == 5'd14) m_epc <= bus.cp0_wdata & ~32'h3;
      end
      m_count <= (bus.we && !m_req() && bus.cp0_addr == 5'd9) ? bus.cp0_wdata : m_count + 32'd1;
      if (bus.we && !m_req() && bus.cp0_addr == 5'd11) begin
        m_compare <= bus.cp0_wdata;
        m_pend    <= 1'b0;
      end else if (m_count == m_compare) begin
        m_pend <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("m_req", {31'b0, bus.req}, {31'b0, m_req()});
      chk("m_rdata", bus.cp0_rdata, m_rd(bus.cp0_addr));
      chk("m_epc_out", bus.epc_out,
          (bus.we && bus.cp0_addr == 5'd14) ? (bus.cp0_wdata & ~32'h3) : m_epc);
      chk("m_exc_pc", bus.exc_pc, 32'h0000_4180);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    bus.cp0_addr = a;
    @(negedge clk);
    chk(nm, bus.cp0_rdata, exp);
    tick();
  endtask

  initial begin
    bit got;
    reset = 1'b1;
    bus.we = 1'b0; bus.cp0_addr = '0; bus.cp0_wdata = '0; bus.vpc = '0;
    bus.bd_in = 1'b0; bus.exc_code_in = '0; bus.eret_in = 1'b0; bus.hw_int = '0;
    tick();
    live = 1;
    bus.exc_code_in = 5'd8;
    @(negedge clk);
    chk("req_in_reset", {31'b0, bus.req}, 32'h0);
    tick();
    bus.exc_code_in = 5'd0;
    reset = 1'b0;

    rd_chk("prid", 5'd15, 32'h4255_4141);
    rd_chk("sr_rst", 5'd12, 32'h0);
    rd_chk("cause_rst", 5'd13, 32'h0);
    rd_chk("epc_rst", 5'd14, 32'h0);
    rd_chk("addr3", 5'd3, 32'h0);
    rd_chk("compare_rst", 5'd11, 32'hFFFF_FFFF);

    // hardware interrupt on IP[10]
    bus.we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_0401;
    tick();
    bus.we = 1'b0; bus.hw_int = 6'b000001; bus.vpc = 32'h0000_1000;
    @(negedge clk);
    chk("int_req", {31'b0, bus.req}, 32'h1);
    tick();
    bus.cp0_addr = 5'd13;
    @(negedge clk);
    chk("int_held_masked", {31'b0, bus.req}, 32'h0);
    chk("int_cause", bus.cp0_rdata, 32'h0000_0400);
    tick();
    rd_chk("int_epc", 5'd14, 32'h0000_1000);
    rd_chk("int_sr", 5'd12, 32'h0000_0403);
    bus.hw_int = '0; bus.eret_in = 1'b1;
    tick();
    bus.eret_in = 1'b0;
    rd_chk("eret_sr", 5'd12, 32'h0000_0401);

    // syscall in a delay slot
    bus.exc_code_in = 5'd8; bus.bd_in = 1'b1; bus.vpc = 32'h0000_3008;
    @(negedge clk);
    chk("sys_req", {31'b0, bus.req}, 32'h1);
    tick();
    bus.exc_code_in = 5'd0; bus.bd_in = 1'b0;
    rd_chk("sys_epc", 5'd14, 32'h0000_3004);
    bus.eret_in = 1'b1;
    rd_chk("sys_cause", 5'd13, 32'h8000_0020);
    bus.eret_in = 1'b0;
    rd_chk("sys_eret_sr", 5'd12, 32'h0000_0401);

    // EPC bypass
    bus.we = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h0000_3011; bus.eret_in = 1'b1;
    @(negedge clk);
    chk("epc_bypass", bus.epc_out, 32'h0000_3010);
    tick();
    bus.we = 1'b0; bus.eret_in = 1'b0;
    rd_chk("epc_written", 5'd14, 32'h0000_3010);

    // timer interrupt on IP[15]
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.we = 1'b1; bus.cp0_addr = 5'd11; bus.cp0_wdata = 32'd5;
    tick();
    bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_8001;
    tick();
    bus.we = 1'b0; bus.cp0_addr = 5'd9; bus.vpc = 32'h0000_0200;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req) got = 1;
      else tick();
    end
    chk("tim_req_seen", {31'b0, got}, 32'h1);
    chk("tim_count_at_req", bus.cp0_rdata, 32'd6);
    tick();
    rd_chk("tim_cause", 5'd13, 32'h0000_8000);
    bus.we = 1'b1; bus.cp0_addr = 5'd11; bus.cp0_wdata = 32'h0000_0100;
    tick();
    bus.we = 1'b0;
    rd_chk("tim_ip_lag", 5'd13, 32'h0000_8000);
    rd_chk("tim_cleared", 5'd13, 32'h0000_0000);
    bus.we = 1'b1; bus.cp0_addr = 5'd9; bus.cp0_wdata = 32'hFFFF_FFFE;
    tick();
    bus.we = 1'b0;
    rd_chk("cnt_load", 5'd9, 32'hFFFF_FFFE);
    rd_chk("cnt_max", 5'd9, 32'hFFFF_FFFF);
    rd_chk("cnt_wrap", 5'd9, 32'h0000_0000);

    // mtc0 squashed by a same-cycle exception
    bus.eret_in = 1'b1;
    tick();
    bus.eret_in = 1'b0;
    bus.exc_code_in = 5'd8; bus.vpc = 32'h0000_2000;
    bus.we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0;
    @(negedge clk);
    chk("squash_req", {31'b0, bus.req}, 32'h1);
    tick();
    bus.exc_code_in = 5'd0; bus.we = 1'b0;
    rd_chk("squash_sr", 5'd12, 32'h0000_8003);
    rd_chk("squash_epc", 5'd14, 32'h0000_2000);

    // reset while in the handler
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_chk("rst_mid_sr", 5'd12, 32'h0);
    rd_chk("rst_mid_cmp", 5'd11, 32'hFFFF_FFFF);

    live = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
